// File: rtl/efpga_cfu_responder_if.sv
// Core <-> eFPGA custom-function port: request, operands, results,
// config strobe and interrupt lines.
interface efpga_cfu_responder_if #(
  parameter int DATA_W   = 32,
  parameter int IRQ_ID_W = 5
);
  logic                en_i;
  logic [1:0]          operator_i;
  logic [1:0]          delay_i;
  logic [DATA_W-1:0]   operand_a_i;
  logic [DATA_W-1:0]   operand_b_i;
  logic                write_strobe_i;
  logic [DATA_W-1:0]   result_a_o;
  logic [DATA_W-1:0]   result_b_o;
  logic [DATA_W-1:0]   result_c_o;
  logic                fpga_done_o;
  logic                irq_o;
  logic [IRQ_ID_W-1:0] irq_id_o;
  logic                irq_ack_i;

  modport slave (
    input  en_i,
    input  operator_i,
    input  delay_i,
    input  operand_a_i,
    input  operand_b_i,
    input  write_strobe_i,
    input  irq_ack_i,
    output result_a_o,
    output result_b_o,
    output result_c_o,
    output fpga_done_o,
    output irq_o,
    output irq_id_o
  );

  modport master (
    output en_i,
    output operator_i,
    output delay_i,
    output operand_a_i,
    output operand_b_i,
    output write_strobe_i,
    output irq_ack_i,
    input  result_a_o,
    input  result_b_o,
    input  result_c_o,
    input  fpga_done_o,
    input  irq_o,
    input  irq_id_o
  );
endinterface

// File: rtl/efpga_cfu_responder.sv
// eFPGA result-side responder: ADD/MUL/LOGIC/MAC with programmable
// latency, 4-phase done handshake and a level completion interrupt.
module efpga_cfu_responder #(
  parameter int DATA_W   = 32,
  parameter int IRQ_ID_W = 5
) (
  input logic wb_clk_i,
  input logic wb_rst_ni,
  efpga_cfu_responder_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_LOG = 2'b10;
  localparam logic [1:0] OP_MAC = 2'b11;

  state_e state_q, state_d;

  logic [1:0]          op_q;
  logic [2:0]          cnt_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [DATA_W-1:0]   res_a_q, res_b_q, res_c_q;
  logic [DATA_W-1:0]   acc_q, opcnt_q;
  logic [IRQ_ID_W:0]   cfg_q;
  logic                irq_q;
  logic [IRQ_ID_W-1:0] irq_id_q;

  logic                accept, fire, done;
  logic [2:0]          lat_m1;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W:0]     sum;
  logic [DATA_W-1:0]   acc_new, opcnt_inc;
  logic [DATA_W-1:0]   ra_d, rb_d, rc_d;
  logic                cfg_clr;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.en_i) state_d = BUSY;
      BUSY: begin
        if (!bus.en_i)       state_d = IDLE;
        else if (cnt_q == 0) state_d = DONE;
      end
      DONE: if (!bus.en_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    accept = (state_q == IDLE) && bus.en_i;
    fire   = (state_q == BUSY) && bus.en_i && (cnt_q == 0);
    done   = (state_q == DONE);
  end

  always_comb begin
    unique case (bus.delay_i)
      2'd0:    lat_m1 = 3'd0;
      2'd1:    lat_m1 = 3'd1;
      2'd2:    lat_m1 = 3'd3;
      default: lat_m1 = 3'd7;
    endcase
  end

  always_comb begin
    prod      = {{DATA_W{1'b0}}, a_q} * {{DATA_W{1'b0}}, b_q};
    sum       = {1'b0, a_q} + {1'b0, b_q};
    acc_new   = acc_q + prod[DATA_W-1:0];
    opcnt_inc = opcnt_q + 1'b1;
    ra_d      = '0;
    rb_d      = '0;
    rc_d      = '0;
    unique case (op_q)
      OP_ADD: begin
        ra_d = sum[DATA_W-1:0];
        rb_d = a_q - b_q;
        rc_d = {{(DATA_W-2){1'b0}}, (a_q < b_q), sum[DATA_W]};
      end
      OP_MUL: begin
        ra_d = prod[DATA_W-1:0];
        rb_d = prod[2*DATA_W-1:DATA_W];
      end
      OP_LOG: begin
        ra_d = a_q & b_q;
        rb_d = a_q | b_q;
        rc_d = a_q ^ b_q;
      end
      OP_MAC: begin
        ra_d = acc_new;
        rb_d = opcnt_inc;
        rc_d = prod[2*DATA_W-1:DATA_W];
      end
      default: ;
    endcase
  end

  assign cfg_clr = bus.write_strobe_i && bus.operand_a_i[DATA_W-1];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      op_q  <= '0;
      cnt_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else if (accept) begin
      op_q  <= bus.operator_i;
      cnt_q <= lat_m1;
      a_q   <= bus.operand_a_i;
      b_q   <= bus.operand_b_i;
    end else if (state_q == BUSY && cnt_q != 0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      res_a_q <= '0;
      res_b_q <= '0;
      res_c_q <= '0;
    end else if (fire) begin
      res_a_q <= ra_d;
      res_b_q <= rb_d;
      res_c_q <= rc_d;
    end
  end

  // A clearing config write beats a coincident completion.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      acc_q   <= '0;
      opcnt_q <= '0;
    end else if (cfg_clr) begin
      acc_q   <= '0;
      opcnt_q <= '0;
    end else if (fire) begin
      opcnt_q <= opcnt_inc;
      if (op_q == OP_MAC) acc_q <= acc_new;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)              cfg_q <= '0;
    else if (bus.write_strobe_i) cfg_q <= bus.operand_a_i[IRQ_ID_W:0];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else if (fire && cfg_q[0]) begin
      irq_q    <= 1'b1;
      irq_id_q <= cfg_q[IRQ_ID_W:1];
    end else if (bus.irq_ack_i) begin
      irq_q    <= 1'b0;
    end
  end

  assign bus.result_a_o  = res_a_q;
  assign bus.result_b_o  = res_b_q;
  assign bus.result_c_o  = res_c_q;
  assign bus.fpga_done_o = done;
  assign bus.irq_o       = irq_q;
  assign bus.irq_id_o    = irq_id_q;

endmodule
